led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised LED pattern generator for board bring-up and status display. It supports N LEDs, a programmable step period with runtime speed scaling, and four display modes: binary count, bounce scanner, blink-all and PWM breathing. It also provides pause/single-step control and selectable output polarity. It sits directly on board LED pins and is driven from the single system clock.

Parameters:
NUM_LEDS, 6, number of LED outputs (>=1)
TICK_DIV, 13500000, clock cycles per pattern step at speed=0 (>=8)
PWM_BITS, 8, breathing-mode duty/PWM counter width (>=2)
ACTIVE_LOW, 1, 1 = LED lit when pin low (output inverted); 0 = active-high

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
mode  input  2  0=binary, 1=scanner, 2=blink-all, 3=breathing
speed  input  2  step period = TICK_DIV >> speed cycles
pause  input  1  level; freezes prescaler and pattern state
step  input  1  one-cycle pulse; forces a single step while paused
led  output  NUM_LEDS  LED drive, polarity per ACTIVE_LOW
tick  output  1  one-cycle pulse on every pattern step

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state updates on the rising edge of clk.
- Reset: prescaler=0, binary count=0, scanner pos=0 dir=up, blink phase=0, duty=0 dir=up, pwm counter=0, mode_q=0. tick=0. led = all-off (all ones if ACTIVE_LOW, else all zeros). Reset overrides every other input.
- Prescaler: limit = TICK_DIV >> speed. It counts 0..limit-1. At count limit-1 it wraps to 0 and generates step_en. A speed change takes effect immediately. If the current count is >= the new limit-1, the prescaler wraps and steps on that cycle.
- Pause: while pause=1 the prescaler holds and there is no step_en. A step pulse while paused produces exactly one step_en in that cycle. step is ignored when pause=0.
- Mode change: mode_q registers mode. On any cycle where mode != mode_q:
  - The prescaler clears to 0 and all pattern state returns to its reset value.
  - No step occurs and tick=0 that cycle.
- On step_en: pattern state advances, and tick=1 on the same edge (registered).
- Mode 0, binary: pattern = count. count increments and wraps from 2^NUM_LEDS-1 to 0.
- Mode 1, scanner: pattern = one-hot(pos). pos moves up to NUM_LEDS-1, then reverses down to 0, then reverses up; end LEDs are not repeated. Sequence: 0,1,..,N-1,N-2,..,1,0,1. When NUM_LEDS=1, pos stays 0.
- Mode 2, blink: phase toggles on each step. pattern = all ones when phase=1, all zeros when phase=0. The first step lights all LEDs.
- Mode 3, breathing:
  - duty (PWM_BITS wide) moves by 1 on each step. Going up, it reverses at 2^PWM_BITS-1; going down, it reverses at 0. Endpoints are held for exactly one step.
  - pwm counter free-runs every clk, wraps, and runs regardless of pause.
  - Every LED is lit when pwm_cnt < duty. duty=0 means always off.
- Output: led is registered. led = ACTIVE_LOW ? ~pattern : pattern, using the post-update state, so led changes on the same edge as tick.
- Widths: count is NUM_LEDS bits; the prescaler is sized for TICK_DIV-1; there are no overflow paths beyond the stated wraps.

Test Plan:
All scenarios use NUM_LEDS=6, TICK_DIV=8, PWM_BITS=3, ACTIVE_LOW=1 unless stated.
1. Reset, then binary count: hold rst 3 cycles -> led=6'b111111, tick=0. Release with mode=0, speed=0 -> tick every 8 cycles. led=6'b111110 after 1st tick, 6'b111101 after 2nd. After 64 ticks led returns to 6'b111111.
2. Scanner: mode=1 -> led walks 111110,111101,111011,110111,101111,011111, then 101111,...,111110, then 111101. tick period is 8.
3. Speed scaling: speed=1 -> tick every 4 cycles. speed=3 -> tick every cycle. Switching from speed 0 to 3 with prescaler=5 -> tick on the next cycle.
4. Pause and step: pause=1 for 50 cycles -> no tick, led stable. A one-cycle step pulse -> exactly one tick, pattern advances one position. step with pause=0 -> no extra tick.
5. Breathing: mode=3, drive 3 steps (duty=3) -> in each 8-cycle PWM window every led bit is low for exactly 3 cycles. Continue to duty=7, then the next step gives duty=6. At duty=0, led=all ones.
6. Reset and mode change mid-operation: in mode 1 at pos=4, assert rst 1 cycle -> led=111111 next edge. After release, pos restarts at 0. Changing mode 0->2 mid-count -> tick=0 that cycle and the next tick occurs 8 cycles later with led=000000.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary count, bounce scanner, blink-all and PWM
// breathing. A prescaler derived from TICK_DIV and the speed input produces the
// pattern step rate; pause/step allow freezing and single-stepping the pattern.
// The LED outputs are registered and can be driven active-low or active-high.
module led_pattern_gen #(
    parameter int NUM_LEDS   = 6,
    parameter int TICK_DIV   = 13500000,
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    input  logic                pause,
    input  logic                step,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    // Prescaler only has to hold TICK_DIV-1.
    localparam int PRE_W = $clog2(TICK_DIV);
    // The scanner position needs at least one bit, even for a single LED.
    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    // XOR mask that turns a logical pattern into pin levels.
    localparam logic [NUM_LEDS-1:0] LED_OFF  = {NUM_LEDS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    // Registered state
    mode_t               r_mode_q;
    logic [PRE_W-1:0]    r_presc;
    logic [NUM_LEDS-1:0] r_count;
    logic [POS_W-1:0]    r_pos;
    logic                r_scan_down;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_duty_down;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_tick;
    logic [NUM_LEDS-1:0] r_led;

    // Next-state values
    logic                w_mode_chg;
    logic [31:0]         w_limit_m1;
    logic                w_step_en;
    logic [PRE_W-1:0]    w_presc_next;
    logic [NUM_LEDS-1:0] w_count_next;
    logic [POS_W-1:0]    w_pos_next;
    logic                w_scan_down_next;
    logic                w_phase_next;
    logic [PWM_BITS-1:0] w_duty_next;
    logic                w_duty_down_next;
    logic [PWM_BITS-1:0] w_pwm_next;
    logic                w_breathe_on;
    logic [NUM_LEDS-1:0] w_pattern;
    logic [NUM_LEDS-1:0] w_led_next;

    // Prescaler and step generation; a mode change restarts the step period.
    always_comb begin
        w_mode_chg   = (mode != r_mode_q);
        w_limit_m1   = (32'(TICK_DIV) >> speed) - 32'd1;
        w_presc_next = r_presc;
        w_step_en    = 1'b0;
        if (w_mode_chg) begin
            w_presc_next = '0;
        end else if (pause) begin
            // Prescaler frozen; a step pulse forces exactly one pattern step.
            w_step_en = step;
        end else if (32'(r_presc) >= w_limit_m1) begin
            // ">=" so that a speed increase that leaves the count past the
            // new limit wraps right away instead of running to overflow.
            w_presc_next = '0;
            w_step_en    = 1'b1;
        end else begin
            w_presc_next = r_presc + PRE_W'(1);
        end
    end

    // Pattern state update for the active mode; mode change resets everything.
    always_comb begin
        w_count_next     = r_count;
        w_pos_next       = r_pos;
        w_scan_down_next = r_scan_down;
        w_phase_next     = r_phase;
        w_duty_next      = r_duty;
        w_duty_down_next = r_duty_down;
        // PWM counter free-runs, independent of pause and mode.
        w_pwm_next       = r_pwm + PWM_BITS'(1);
        if (w_mode_chg) begin
            w_count_next     = '0;
            w_pos_next       = '0;
            w_scan_down_next = 1'b0;
            w_phase_next     = 1'b0;
            w_duty_next      = '0;
            w_duty_down_next = 1'b0;
        end else if (w_step_en) begin
            case (r_mode_q)
                MODE_BINARY: begin
                    w_count_next = r_count + NUM_LEDS'(1);
                end
                MODE_SCAN: begin
                    // Direction flips when an end is reached, so each end
                    // position is shown for a single step only.
                    if (NUM_LEDS > 1) begin
                        if (!r_scan_down) begin
                            w_pos_next = r_pos + POS_W'(1);
                            if (w_pos_next == POS_MAX) begin
                                w_scan_down_next = 1'b1;
                            end
                        end else begin
                            w_pos_next = r_pos - POS_W'(1);
                            if (w_pos_next == '0) begin
                                w_scan_down_next = 1'b0;
                            end
                        end
                    end
                end
                MODE_BLINK: begin
                    w_phase_next = ~r_phase;
                end
                default: begin
                    // Triangle sweep of duty with single-step endpoints.
                    if (!r_duty_down) begin
                        w_duty_next = r_duty + PWM_BITS'(1);
                        if (w_duty_next == DUTY_MAX) begin
                            w_duty_down_next = 1'b1;
                        end
                    end else begin
                        w_duty_next = r_duty - PWM_BITS'(1);
                        if (w_duty_next == '0) begin
                            w_duty_down_next = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Breathing: all LEDs lit while the PWM counter is below the duty value.
    assign w_breathe_on = (w_pwm_next < w_duty_next);

    // Per-LED pattern bit, selected by the mode that will be in effect after
    // this edge (the registered mode always follows the input).
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_pattern
            assign w_pattern[gi] =
                (mode == MODE_BINARY) ? w_count_next[gi] :
                (mode == MODE_SCAN)   ? (w_pos_next == POS_W'(gi)) :
                (mode == MODE_BLINK)  ? w_phase_next :
                                        w_breathe_on;
        end
    endgenerate

    assign w_led_next = w_pattern ^ LED_OFF;

    // State register, registered tick and LED outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q    <= MODE_BINARY;
            r_presc     <= '0;
            r_count     <= '0;
            r_pos       <= '0;
            r_scan_down <= 1'b0;
            r_phase     <= 1'b0;
            r_duty      <= '0;
            r_duty_down <= 1'b0;
            r_pwm       <= '0;
            r_tick      <= 1'b0;
            r_led       <= LED_OFF;
        end else begin
            r_mode_q    <= mode_t'(mode);
            r_presc     <= w_presc_next;
            r_count     <= w_count_next;
            r_pos       <= w_pos_next;
            r_scan_down <= w_scan_down_next;
            r_phase     <= w_phase_next;
            r_duty      <= w_duty_next;
            r_duty_down <= w_duty_down_next;
            r_pwm       <= w_pwm_next;
            r_tick      <= w_step_en;
            r_led       <= w_led_next;
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen with NUM_LEDS=6, TICK_DIV=8, PWM_BITS=3,
// active-low outputs. A cycle-level reference model tracks the step count per
// mode and derives the expected display from it arithmetically.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed = 2'd0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic [5:0] led;
    logic       tick;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int   m_mode_q = 0;
    int   m_presc  = 0;
    int   m_k      = 0;   // steps taken since the mode was entered
    int   m_pwm    = 0;
    logic m_tick   = 1'b0;

    led_pattern_gen #(
        .NUM_LEDS  (6),
        .TICK_DIV  (8),
        .PWM_BITS  (3),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .speed(speed),
        .pause(pause),
        .step (step),
        .led  (led),
        .tick (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected pin levels from the step count of the current mode.
    function automatic logic [5:0] exp_led();
        int p;
        int pos;
        int duty;
        logic [5:0] pat;
        case (m_mode_q)
            0: pat = 6'(m_k % 64);
            1: begin
                p   = m_k % 10;
                pos = (p <= 5) ? p : 10 - p;
                pat = 6'(1 << pos);
            end
            2: pat = (m_k % 2 == 1) ? 6'h3F : 6'h00;
            default: begin
                p    = m_k % 14;
                duty = (p <= 7) ? p : 14 - p;
                pat  = (m_pwm < duty) ? 6'h3F : 6'h00;
            end
        endcase
        return ~pat;
    endfunction

    // One clock: update the model from the inputs sampled at the edge.
    task automatic advance();
        int lim;
        @(posedge clk);
        if (rst) begin
            m_mode_q = 0; m_presc = 0; m_k = 0; m_pwm = 0; m_tick = 1'b0;
        end else begin
            m_pwm = (m_pwm + 1) % 8;
            lim   = 8 >> speed;
            if (int'(mode) != m_mode_q) begin
                m_presc = 0; m_k = 0; m_tick = 1'b0;
            end else if (pause) begin
                m_tick = step;
            end else if (m_presc >= lim - 1) begin
                m_presc = 0; m_tick = 1'b1;
            end else begin
                m_presc++; m_tick = 1'b0;
            end
            if (m_tick) m_k++;
            m_mode_q = int'(mode);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            advance();
            n_vec++;
            if (led !== 6'h3F || tick !== 1'b0) begin
                n_err++;
                $display("FAIL reset: led=%b tick=%b want led=111111 tick=0", led, tick);
            end
        end
    endtask

    task automatic test_binary();
        int ticks = 0;
        int last = -1;
        rst = 1'b0; mode = 2'd0; speed = 2'd0; pause = 1'b0; step = 1'b0;
        for (int c = 0; c < 600 && ticks < 64; c++) begin
            advance();
            n_vec++;
            if (tick !== m_tick || led !== exp_led()) begin
                n_err++;
                $display("FAIL binary_model: cyc=%0d led=%b tick=%b want led=%b tick=%b",
                         c, led, tick, exp_led(), m_tick);
            end
            if (tick === 1'b1) begin
                ticks++;
                if (last >= 0) begin
                    n_vec++;
                    if (c - last != 8) begin
                        n_err++;
                        $display("FAIL binary_period: got %0d want 8", c - last);
                    end
                end
                last = c;
                if (ticks == 1 || ticks == 2 || ticks == 64) begin
                    n_vec++;
                    if (led !== ((ticks == 1) ? 6'b111110 : (ticks == 2) ? 6'b111101 : 6'b111111)) begin
                        n_err++;
                        $display("FAIL binary_tick%0d: led=%b", ticks, led);
                    end
                end
            end
        end
        n_vec++;
        if (ticks != 64) begin
            n_err++;
            $display("FAIL binary_ticks: got %0d want 64", ticks);
        end
    endtask

    task automatic test_scanner();
        logic [5:0] seq [12] = '{6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111, 6'b101111,
                                 6'b110111, 6'b111011, 6'b111101, 6'b111110, 6'b111101, 6'b111011};
        int ticks = 0;
        int last = -1;
        mode = 2'd1;
        for (int c = 0; c < 200 && ticks < 12; c++) begin
            advance();
            n_vec++;
            if (tick !== m_tick || led !== exp_led()) begin
                n_err++;
                $display("FAIL scanner_model: cyc=%0d led=%b tick=%b want led=%b tick=%b",
                         c, led, tick, exp_led(), m_tick);
            end
            if (tick === 1'b1) begin
                n_vec++;
                if (led !== seq[ticks]) begin
                    n_err++;
                    $display("FAIL scanner_seq%0d: led=%b want %b", ticks, led, seq[ticks]);
                end
                if (last >= 0) begin
                    n_vec++;
                    if (c - last != 8) begin
                        n_err++;
                        $display("FAIL scanner_period: got %0d want 8", c - last);
                    end
                end
                last = c;
                ticks++;
            end
        end
        n_vec++;
        if (ticks != 12) begin
            n_err++;
            $display("FAIL scanner_ticks: got %0d want 12", ticks);
        end
    endtask

    task automatic test_speed();
        int ticks;
        int last;
        logic got;
        for (int s = 1; s <= 3; s += 2) begin
            speed = 2'(s);
            ticks = 0; last = -1;
            for (int c = 0; c < 100 && ticks < 5; c++) begin
                advance();
                n_vec++;
                if (tick !== m_tick || led !== exp_led()) begin
                    n_err++;
                    $display("FAIL speed_model: s=%0d led=%b tick=%b want led=%b tick=%b",
                             s, led, tick, exp_led(), m_tick);
                end
                if (tick === 1'b1) begin
                    if (last >= 0) begin
                        n_vec++;
                        if (c - last != (8 >> s)) begin
                            n_err++;
                            $display("FAIL speed_period: s=%0d got %0d want %0d", s, c - last, 8 >> s);
                        end
                    end
                    last = c;
                    ticks++;
                end
            end
        end
        // Speed 0 -> 3 with the prescaler at 5.
        speed = 2'd0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            advance();
            got = (tick === 1'b1);
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL speed_sync: no tick within 20 cycles");
        end
        repeat (5) begin
            advance();
            n_vec++;
            if (tick !== 1'b0) begin
                n_err++;
                $display("FAIL speed_count: tick=%b want 0", tick);
            end
        end
        speed = 2'd3;
        advance();
        n_vec++;
        if (tick !== 1'b1 || led !== exp_led()) begin
            n_err++;
            $display("FAIL speed_switch: tick=%b led=%b want tick=1 led=%b", tick, led, exp_led());
        end
    endtask

    task automatic test_pause();
        speed = 2'd0;
        pause = 1'b1;
        repeat (50) begin
            advance();
            n_vec++;
            if (tick !== 1'b0 || led !== exp_led()) begin
                n_err++;
                $display("FAIL pause_hold: tick=%b led=%b want tick=0 led=%b", tick, led, exp_led());
            end
        end
        step = 1'b1;
        advance();
        step = 1'b0;
        n_vec++;
        if (tick !== 1'b1 || led !== exp_led()) begin
            n_err++;
            $display("FAIL pause_step: tick=%b led=%b want tick=1 led=%b", tick, led, exp_led());
        end
        advance();
        n_vec++;
        if (tick !== 1'b0 || led !== exp_led()) begin
            n_err++;
            $display("FAIL pause_single: tick=%b led=%b want tick=0 led=%b", tick, led, exp_led());
        end
        pause = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step = (c == 2);
            advance();
            n_vec++;
            if (tick !== m_tick || led !== exp_led()) begin
                n_err++;
                $display("FAIL step_unpaused: c=%0d tick=%b led=%b want tick=%b led=%b",
                         c, tick, led, m_tick, exp_led());
            end
        end
        step = 1'b0;
    endtask

    task automatic test_breathing();
        int steps [4] = '{3, 4, 1, 6};
        int duty  [4] = '{3, 7, 6, 0};
        int lit;
        pause = 1'b1; speed = 2'd0; mode = 2'd3;
        advance();
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < steps[ph]; i++) begin
                step = 1'b1;
                advance();
                step = 1'b0;
                n_vec++;
                if (tick !== 1'b1) begin
                    n_err++;
                    $display("FAIL breathe_step: tick=%b want 1", tick);
                end
            end
            lit = 0;
            for (int c = 0; c < 8; c++) begin
                advance();
                n_vec++;
                if ((led !== 6'h00 && led !== 6'h3F) || led !== exp_led()) begin
                    n_err++;
                    $display("FAIL breathe_pwm: duty=%0d led=%b want %b", duty[ph], led, exp_led());
                end
                if (led === 6'h00) lit++;
            end
            n_vec++;
            if (lit != duty[ph]) begin
                n_err++;
                $display("FAIL breathe_duty: lit cycles %0d want %0d", lit, duty[ph]);
            end
        end
    endtask

    task automatic test_mode_reset();
        int c;
        pause = 1'b1; mode = 2'd1;
        advance();
        repeat (4) begin
            step = 1'b1;
            advance();
            step = 1'b0;
        end
        n_vec++;
        if (led !== 6'b101111) begin
            n_err++;
            $display("FAIL scan_pos4: led=%b want 101111", led);
        end
        rst = 1'b1;
        advance();
        rst = 1'b0;
        n_vec++;
        if (led !== 6'h3F || tick !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: led=%b tick=%b want 111111 0", led, tick);
        end
        pause = 1'b0; speed = 2'd0;
        c = 0;
        do begin
            advance();
            c++;
        end while (tick !== 1'b1 && c < 20);
        n_vec++;
        if (tick !== 1'b1 || led !== 6'b111101) begin
            n_err++;
            $display("FAIL scan_restart: tick=%b led=%b want 1 111101", tick, led);
        end
        mode = 2'd0;
        repeat (14) advance();
        mode = 2'd2;
        advance();
        n_vec++;
        if (tick !== 1'b0 || led !== 6'h3F) begin
            n_err++;
            $display("FAIL mode_change: tick=%b led=%b want 0 111111", tick, led);
        end
        c = 0;
        do begin
            advance();
            c++;
        end while (tick !== 1'b1 && c < 20);
        n_vec++;
        if (c != 8 || led !== 6'h00) begin
            n_err++;
            $display("FAIL blink_first: cycles=%0d led=%b want 8 000000", c, led);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(29) == 0) speed = 2'($urandom_range(3));
            if ($urandom_range(19) == 0) pause = ~pause;
            step = ($urandom_range(3) == 0);
            advance();
            n_vec++;
            if (tick !== m_tick || (m_mode_q != 3 && led !== exp_led())) begin
                n_err++;
                $display("FAIL random: c=%0d mode=%0d led=%b tick=%b want led=%b tick=%b",
                         c, m_mode_q, led, tick, exp_led(), m_tick);
            end
        end
        rst = 1'b0; step = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_binary();
        test_scanner();
        test_speed();
        test_pause();
        test_breathing();
        test_mode_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
